i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arb_pkg.sv | 21 ++
 rtl/i2c_arb_picker.sv | 45 ++++
 rtl/i2c_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared state encoding and default sizing for the I2C arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int c_DEF_NUM_REQ    = 4;
    localparam int c_DEF_ADDR_BYTES = 1;
    localparam int c_DEF_DATA_BYTES = 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESP      = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_arb_picker.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_picker
// Description : Combinational rotate-and-priority encoder; the search starts
//               at ptr and wraps modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_arb_picker
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    int               w_pos;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        w_pos      = 0;
        w_sel      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_sel = IDX_W'(w_pos);
            if (!any_req && req[w_sel]) begin
                any_req       = 1'b1;
                winner[w_sel] = 1'b1;
                winner_idx    = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arbiter
// Description : Shares one single-transfer I2C master among NUM_REQ requesters.
//               Round-robin by default; define I2C_ARB_FIXED_PRIO_EN for fixed
//               priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ    = c_DEF_NUM_REQ,
    parameter int ADDR_BYTES = c_DEF_ADDR_BYTES,
    parameter int DATA_BYTES = c_DEF_DATA_BYTES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_rd,
    input  logic [7*NUM_REQ-1:0]              req_chip_addr,
    input  logic [8*ADDR_BYTES*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*DATA_BYTES*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                ack,
    output logic [8*DATA_BYTES-1:0]           rsp_rdata,
    output logic [ADDR_BYTES+DATA_BYTES:0]    rsp_status,
    output logic [6:0]                        m_chip_addr,
    output logic [8*ADDR_BYTES-1:0]           m_reg_addr,
    output logic [8*DATA_BYTES-1:0]           m_data_in,
    output logic                              m_write_en,
    output logic                              m_read_en,
    output logic                              m_write_mode,
    input  logic [8*DATA_BYTES-1:0]           m_data_out,
    input  logic [ADDR_BYTES+DATA_BYTES:0]    m_status,
    input  logic                              m_done,
    input  logic                              m_busy
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_AW    = 8 * ADDR_BYTES;
    localparam int c_DW    = 8 * DATA_BYTES;
    localparam int c_SW    = 1 + ADDR_BYTES + DATA_BYTES;

    arb_state_t          r_state;
    arb_state_t          w_state_next;

    logic [NUM_REQ-1:0]  w_winner;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_IDX_W-1:0]  w_ptr;
    logic                w_any;

    logic                w_sel_rd;
    logic [6:0]          w_sel_chip;
    logic [c_AW-1:0]     w_sel_reg;
    logic [c_DW-1:0]     w_sel_wdata;

    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_rd;
    logic                r_wen;
    logic                r_ren;
    logic [6:0]          r_chip;
    logic [c_AW-1:0]     r_reg;
    logic [c_DW-1:0]     r_wdata;
    logic [c_DW-1:0]     r_rdata;
    logic [c_SW-1:0]     r_status;

    i2c_arb_picker #(
        .NUM_REQ    (NUM_REQ),
        .IDX_W      (c_IDX_W)
    ) u_picker (
        .req        (req),
        .ptr        (w_ptr),
        .winner     (w_winner),
        .winner_idx (w_idx),
        .any_req    (w_any)
    );

    // One-hot winner drives an AND-OR mux over the packed requester fields.
    always_comb begin
        w_sel_rd    = 1'b0;
        w_sel_chip  = '0;
        w_sel_reg   = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) begin
                w_sel_rd    = req_rd[i];
                w_sel_chip  = req_chip_addr[7*i +: 7];
                w_sel_reg   = req_reg_addr[c_AW*i +: c_AW];
                w_sel_wdata = req_wdata[c_DW*i +: c_DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_any)  w_state_next = S_ISSUE;
            S_ISSUE:     if (m_busy) w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (m_done) w_state_next = S_RESP;
            S_RESP:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt    <= '0;
            r_ack    <= '0;
            r_rd     <= 1'b0;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
            r_chip   <= '0;
            r_reg    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_status <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_winner;
                        r_rd    <= w_sel_rd;
                        r_wen   <= ~w_sel_rd;
                        r_ren   <= w_sel_rd;
                        r_chip  <= w_sel_chip;
                        r_reg   <= w_sel_reg;
                        r_wdata <= w_sel_wdata;
                    end
                end
                S_ISSUE: begin
                    if (m_busy) begin
                        r_wen <= 1'b0;
                        r_ren <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (m_done) begin
                        if (r_rd) begin
                            r_rdata <= m_data_out;
                        end
                        r_status <= m_status;
                    end
                end
                S_RESP: begin
                    r_ack <= r_gnt;
                    r_gnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef I2C_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_idx;

    // Pointer advances past the served requester once the response is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_idx <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_idx <= w_idx;
            end
            if (r_state == S_RESP) begin
                r_ptr <= (r_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

    assign w_ptr = r_ptr;
`endif

    assign gnt          = r_gnt;
    assign ack          = r_ack;
    assign rsp_rdata    = r_rdata;
    assign rsp_status   = r_status;
    assign m_chip_addr  = r_chip;
    assign m_reg_addr   = r_reg;
    assign m_data_in    = r_wdata;
    assign m_write_en   = r_wen;
    assign m_read_en    = r_ren;
    assign m_write_mode = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_arbiter
// Description : Scoreboard bench for i2c_arbiter with a behavioural master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_arbiter;

    localparam int NR = 4;
    localparam int AB = 1;
    localparam int DB = 2;
    localparam int SW = 1 + AB + DB;

    logic                 clk;
    logic                 reset;
    logic [NR-1:0]        req;
    logic [NR-1:0]        req_rd;
    logic [7*NR-1:0]      req_chip_addr;
    logic [8*AB*NR-1:0]   req_reg_addr;
    logic [8*DB*NR-1:0]   req_wdata;
    logic [NR-1:0]        gnt;
    logic [NR-1:0]        ack;
    logic [8*DB-1:0]      rsp_rdata;
    logic [SW-1:0]        rsp_status;
    logic [6:0]           m_chip_addr;
    logic [8*AB-1:0]      m_reg_addr;
    logic [8*DB-1:0]      m_data_in;
    logic                 m_write_en;
    logic                 m_read_en;
    logic                 m_write_mode;
    logic [8*DB-1:0]      m_data_out;
    logic [SW-1:0]        m_status;
    logic                 m_done;
    logic                 m_busy;

    i2c_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_BYTES (AB),
        .DATA_BYTES (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_rd        (req_rd),
        .req_chip_addr (req_chip_addr),
        .req_reg_addr  (req_reg_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .ack           (ack),
        .rsp_rdata     (rsp_rdata),
        .rsp_status    (rsp_status),
        .m_chip_addr   (m_chip_addr),
        .m_reg_addr    (m_reg_addr),
        .m_data_in     (m_data_in),
        .m_write_en    (m_write_en),
        .m_read_en     (m_read_en),
        .m_write_mode  (m_write_mode),
        .m_data_out    (m_data_out),
        .m_status      (m_status),
        .m_done        (m_done),
        .m_busy        (m_busy)
    );

    typedef struct {
        int          idx;
        logic [15:0] rdata;
        logic [3:0]  status;
        logic [6:0]  chip;
        logic [15:0] din;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    logic [15:0] mdl_rdata = '0;
    logic [3:0]  mdl_status = '0;
    logic [15:0] exp_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Behavioural master: busy for three cycles, then a one-cycle done.
    initial begin
        m_busy     = 1'b0;
        m_done     = 1'b0;
        m_data_out = '0;
        m_status   = '0;
        forever begin
            @(negedge clk);
            if (!reset && (m_write_en || m_read_en) && !m_busy) begin
                m_busy = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (reset) break;
                end
                m_busy = 1'b0;
                if (!reset) begin
                    m_data_out = mdl_rdata;
                    m_status   = mdl_status;
                    m_done     = 1'b1;
                    done_cyc   = cyc;
                    @(negedge clk);
                    m_done     = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
        if (!reset && (|ack)) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("ack_idx",     64'(ack),         64'(1) << mon_e.idx);
                chk("rsp_rdata",   64'(rsp_rdata),   64'(mon_e.rdata));
                chk("rsp_status",  64'(rsp_status),  64'(mon_e.status));
                chk("m_chip_addr", 64'(m_chip_addr), 64'(mon_e.chip));
                chk("m_data_in",   64'(m_data_in),   64'(mon_e.din));
                chk("done_to_ack", 64'(cyc - done_cyc), 64'd2);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_gnt"},        64'(gnt),          64'd0);
        chk({tag, "_ack"},        64'(ack),          64'd0);
        chk({tag, "_wen"},        64'(m_write_en),   64'd0);
        chk({tag, "_ren"},        64'(m_read_en),    64'd0);
        chk({tag, "_chip"},       64'(m_chip_addr),  64'd0);
        chk({tag, "_reg"},        64'(m_reg_addr),   64'd0);
        chk({tag, "_din"},        64'(m_data_in),    64'd0);
        chk({tag, "_rdata"},      64'(rsp_rdata),    64'd0);
        chk({tag, "_status"},     64'(rsp_status),   64'd0);
        chk({tag, "_write_mode"}, 64'(m_write_mode), 64'd0);
    endtask

    task automatic wait_ack(input string tag);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (|ack) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_ack_seen"}, 64'(got), 64'd1);
    endtask

    task automatic run_single(input string tag, input int i, input bit rd,
                              input logic [6:0] chip, input logic [7:0] ra,
                              input logic [15:0] wd, input logic [15:0] rdat,
                              input logic [3:0] st, input bit tamper);
        exp_t e;
        req_rd[i]              = rd;
        req_chip_addr[7*i +: 7] = chip;
        req_reg_addr[8*i +: 8]  = ra;
        req_wdata[16*i +: 16]   = wd;
        mdl_rdata  = rdat;
        mdl_status = st;
        if (rd) exp_rdata = rdat;
        e.idx = i; e.rdata = exp_rdata; e.status = st; e.chip = chip; e.din = wd;
        q.push_back(e);
        req[i] = 1'b1;
        @(negedge clk);
        chk({tag, "_gnt"},  64'(gnt),         64'(1) << i);
        chk({tag, "_wen"},  64'(m_write_en),  64'(!rd));
        chk({tag, "_ren"},  64'(m_read_en),   64'(rd));
        chk({tag, "_chip"}, 64'(m_chip_addr), 64'(chip));
        chk({tag, "_reg"},  64'(m_reg_addr),  64'(ra));
        req[i] = 1'b0;
        if (tamper) req_wdata[16*i +: 16] = 16'h2222;
        @(negedge clk);
        chk({tag, "_en_dropped"}, 64'(m_write_en | m_read_en), 64'd0);
        wait_ack(tag);
    endtask

    initial begin
        exp_t e;
        bit   got;
        int   k;
        reset         = 1'b1;
        req           = '0;
        req_rd        = '0;
        req_chip_addr = '0;
        req_reg_addr  = '0;
        req_wdata     = '0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        run_single("wr2",   2, 1'b0, 7'h1D, 8'h20, 16'hA55A, 16'h0000, 4'b0000, 1'b0);
        run_single("rd1",   1, 1'b1, 7'h2C, 8'h05, 16'h0000, 16'hBEEF, 4'b0000, 1'b0);
        run_single("hold0", 0, 1'b0, 7'h33, 8'h44, 16'h1111, 16'h0000, 4'b0000, 1'b1);
        run_single("nack3", 3, 1'b0, 7'h50, 8'h10, 16'h0F0F, 16'h0000, 4'b0010, 1'b0);
        run_single("rd1b",  1, 1'b1, 7'h2C, 8'h06, 16'h0000, 16'h1234, 4'b0000, 1'b0);

        // Reset during WAIT_DONE: transfer abandoned, no ack.
        req_rd[2] = 1'b0; req_chip_addr[14 +: 7] = 7'h1D; req_wdata[32 +: 16] = 16'h7777;
        req[2] = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd4);
        req[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = '0;
        repeat (12) @(negedge clk);
        chk("midrst_no_ack", 64'(ack), 64'd0);
        run_single("post3", 3, 1'b0, 7'h13, 8'h01, 16'hC0DE, 16'h0000, 4'b0000, 1'b0);

        // All requesters held high for eight transfers.
        for (int i = 0; i < NR; i++) begin
            req_rd[i]               = 1'b0;
            req_chip_addr[7*i +: 7] = 7'(7'h10 + i);
            req_reg_addr[8*i +: 8]  = 8'(8'h80 + i);
            req_wdata[16*i +: 16]   = 16'(16'h1000 * (i + 1));
        end
        mdl_status = '0;
        for (int n = 0; n < 8; n++) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
            e.idx = 0;
`else
            e.idx = n % NR;
`endif
            e.rdata  = exp_rdata;
            e.status = 4'b0000;
            e.chip   = 7'(7'h10 + e.idx);
            e.din    = 16'(16'h1000 * (e.idx + 1));
            q.push_back(e);
        end
        req = '1;
        k   = 0;
        for (int t = 0; t < 400 && k < 8; t++) begin
            @(negedge clk);
            if (|ack) begin
                k++;
                if (k == 8) req = '0;
            end
        end
        req = '0;
        chk("rr_ack_count", 64'(k), 64'd8);

        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        chk("queue_drained", 64'(got), 64'd1);
        repeat (10) @(negedge clk);
        chk("idle_gnt", 64'(gnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
